// File: rtl/rgb_column_feeder.sv
// Line-buffered column feeder for the RGB 3x3 systolic convolution array.
// Turns a raster RGB stream into per-channel 3-row vertical columns.
module rgb_column_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 224,
    parameter int IMG_HEIGHT = 224
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    input  logic [DATA_WIDTH-1:0]   pix_r,
    input  logic [DATA_WIDTH-1:0]   pix_g,
    input  logic [DATA_WIDTH-1:0]   pix_b,
    output logic [3*DATA_WIDTH-1:0] input_col_r,
    output logic [3*DATA_WIDTH-1:0] input_col_g,
    output logic [3*DATA_WIDTH-1:0] input_col_b,
    output logic                    input_valid,
    output logic                    frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DW = DATA_WIDTH;
    localparam int PW = 3 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t          state;
    state_t          eff_state;
    state_t          next_state;
    logic [XW-1:0]   x;
    logic [XW-1:0]   cur_x;
    logic [XW-1:0]   next_x;
    logic [YW-1:0]   y;
    logic [YW-1:0]   cur_y;
    logic [YW-1:0]   next_y;
    logic            accept;
    logic            last_x;
    logic            last_y;
    logic            emit;
    logic            frame_end;
    logic [PW-1:0]   pix;
    logic [PW-1:0]   lb0_rd;
    logic [PW-1:0]   lb1_rd;

    // Channels packed together: word bits [DW-1:0]=R, next DW=G, MSBs=B.
    logic [PW-1:0]   lb0 [IMG_WIDTH];
    logic [PW-1:0]   lb1 [IMG_WIDTH];

    // A sof pixel is treated as (0,0) of a fresh FILL, whatever the current state.
    always_comb begin
        accept     = pix_valid && (pix_sof || state == FILL || state == STREAM);
        cur_x      = pix_sof ? '0 : x;
        cur_y      = pix_sof ? '0 : y;
        eff_state  = pix_sof ? FILL : state;
        last_x     = (cur_x == XW'(IMG_WIDTH - 1));
        last_y     = (cur_y == YW'(IMG_HEIGHT - 1));
        next_x     = last_x ? '0 : cur_x + 1'b1;
        next_y     = cur_y;
        next_state = eff_state;
        if (last_x) begin
            next_y = last_y ? '0 : cur_y + 1'b1;
            if (eff_state == FILL && cur_y == YW'(1))
                next_state = STREAM;
            else if (eff_state == STREAM && last_y)
                next_state = DONE;
        end
        emit      = accept && (eff_state == STREAM);
        frame_end = emit && last_x && last_y;
        pix       = {pix_b, pix_g, pix_r};
        lb0_rd    = lb0[cur_x];
        lb1_rd    = lb1[cur_x];
    end

    // NOTE: line buffers carry no reset; every entry is rewritten during FILL before it is read out.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[cur_x] <= lb0_rd;
            lb0[cur_x] <= pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            input_valid <= 1'b0;
            frame_done  <= 1'b0;
            input_col_r <= '0;
            input_col_g <= '0;
            input_col_b <= '0;
        end else begin
            input_valid <= emit;
            frame_done  <= frame_end;
            if (accept) begin
                state <= next_state;
                x     <= next_x;
                y     <= next_y;
            end
            // Columns only move with a valid strobe and hold otherwise.
            if (emit) begin
                input_col_r <= {pix_r, lb0_rd[0*DW +: DW], lb1_rd[0*DW +: DW]};
                input_col_g <= {pix_g, lb0_rd[1*DW +: DW], lb1_rd[1*DW +: DW]};
                input_col_b <= {pix_b, lb0_rd[2*DW +: DW], lb1_rd[2*DW +: DW]};
            end
        end
    end

endmodule

// File: tb/tb_rgb_column_feeder.sv
// Directed bench for rgb_column_feeder on a 5x4 frame with R=16y+x, G=R+1, B=R+2.
module tb_rgb_column_feeder;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_sof;
    logic [DW-1:0] pix_r;
    logic [DW-1:0] pix_g;
    logic [DW-1:0] pix_b;
    logic [3*DW-1:0] input_col_r;
    logic [3*DW-1:0] input_col_g;
    logic [3*DW-1:0] input_col_b;
    logic          input_valid;
    logic          frame_done;

    int tests = 0;
    int fails = 0;
    int n_valid;
    int n_done;
    logic [3*DW-1:0] exp_r = '0;
    logic [3*DW-1:0] exp_g = '0;
    logic [3*DW-1:0] exp_b = '0;

    rgb_column_feeder #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .input_col_r(input_col_r),
        .input_col_g(input_col_g),
        .input_col_b(input_col_b),
        .input_valid(input_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pv(input int x, input int y, input int off, input int ch);
        return DW'(16 * y + x + off + ch);
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(input_valid), 32'd0);
        chk({tag, "_done"},  32'(frame_done),  32'd0);
        chk({tag, "_col_r"}, 32'(input_col_r), 32'd0);
        chk({tag, "_col_g"}, 32'(input_col_g), 32'd0);
        chk({tag, "_col_b"}, 32'(input_col_b), 32'd0);
    endtask

    // One input cycle, then checks of the response one cycle later.
    task automatic push(input logic v, input logic sof, input int x, input int y,
                        input int off, input bit exp_v, input bit exp_d);
        @(negedge clk);
        pix_valid = v;
        pix_sof   = sof;
        pix_r     = pv(x, y, off, 0);
        pix_g     = pv(x, y, off, 1);
        pix_b     = pv(x, y, off, 2);
        @(posedge clk);
        #1;
        if (exp_v) begin
            exp_r = {pv(x, y, off, 0), pv(x, y - 1, off, 0), pv(x, y - 2, off, 0)};
            exp_g = {pv(x, y, off, 1), pv(x, y - 1, off, 1), pv(x, y - 2, off, 1)};
            exp_b = {pv(x, y, off, 2), pv(x, y - 1, off, 2), pv(x, y - 2, off, 2)};
        end
        chk("input_valid", 32'(input_valid), 32'(exp_v));
        chk("frame_done",  32'(frame_done),  32'(exp_d));
        chk("input_col_r", 32'(input_col_r), 32'(exp_r));
        chk("input_col_g", 32'(input_col_g), 32'(exp_g));
        chk("input_col_b", 32'(input_col_b), 32'(exp_b));
        if (input_valid) n_valid++;
        if (frame_done)  n_done++;
    endtask

    task automatic send_frame(input int off, input int npix, input bit gap);
        n_valid = 0;
        n_done  = 0;
        for (int i = 0; i < npix; i++) begin
            int px;
            int py;
            px = i % W;
            py = i / W;
            push(1'b1, i == 0, px, py, off, py >= 2, i == W * H - 1);
            if (px == 3 && py == 2 && off == 0)
                chk("col_r_at_3_2", 32'(input_col_r), 32'h231303);
            if (gap)
                push(1'b0, 1'b0, px, py, off, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset held with random inputs.
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_r     = '0;
        pix_g     = '0;
        pix_b     = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_valid = 1'($urandom);
            pix_sof   = 1'($urandom);
            pix_r     = DW'($urandom);
            pix_g     = DW'($urandom);
            pix_b     = DW'($urandom);
            @(posedge clk);
            #1;
            check_outputs_zero("reset");
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst       = 1'b0;

        // No sof yet: 20 pixels must be ignored.
        for (int i = 0; i < 20; i++)
            push(1'b1, 1'b0, i % W, i / W, 0, 1'b0, 1'b0);

        // Continuous full frame.
        send_frame(0, W * H, 1'b0);
        chk("full_valid_count", 32'(n_valid), 32'd10);
        chk("full_done_count",  32'(n_done),  32'd1);

        // Gapped frame: every other cycle idle.
        send_frame(0, W * H, 1'b1);
        chk("gap_valid_count", 32'(n_valid), 32'd10);
        chk("gap_done_count",  32'(n_done),  32'd1);

        // Frame A aborted by sof at its (2,2), then full frame B at +0x80.
        send_frame(0, 12, 1'b0);
        chk("abort_a_valid_count", 32'(n_valid), 32'd2);
        chk("abort_a_done_count",  32'(n_done),  32'd0);
        send_frame(8'h80, W * H, 1'b0);
        chk("frame_b_valid_count", 32'(n_valid), 32'd10);
        chk("frame_b_done_count",  32'(n_done),  32'd1);

        // DONE ignores non-sof pixels.
        n_valid = 0;
        for (int i = 0; i < 7; i++)
            push(1'b1, 1'b0, i % W, 0, 8'h55, 1'b0, 1'b0);
        chk("done_ignore_valid_count", 32'(n_valid), 32'd0);

        // Back-to-back frames, sof directly after the last pixel.
        send_frame(8'h40, W * H, 1'b0);
        chk("b2b_first_valid_count", 32'(n_valid), 32'd10);
        chk("b2b_first_done_count",  32'(n_done),  32'd1);
        send_frame(0, W * H, 1'b0);
        chk("b2b_second_valid_count", 32'(n_valid), 32'd10);
        chk("b2b_second_done_count",  32'(n_done),  32'd1);

        // Async reset while streaming row 3.
        send_frame(8'h10, 17, 1'b0);
        chk("pre_reset_valid", 32'(input_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        exp_r = '0;
        exp_g = '0;
        exp_b = '0;
        for (int i = 0; i < 3; i++)
            push(1'b1, 1'b0, i, 3, 8'h10, 1'b0, 1'b0);
        send_frame(0, W * H, 1'b0);
        chk("post_reset_valid_count", 32'(n_valid), 32'd10);
        chk("post_reset_done_count",  32'(n_done),  32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
